leb128_decoder: RTL and testbench

- Decodes one LEB128 immediate from the instruction byte stream into a 64-bit value for the core's execute stage.
- Sits downstream of the fetch/byte-extract stage fed by genrom and upstream of the execute/stack logic; operands include i32.const, local indices and branch depths.
- Accepts one byte per cycle with valid/ready on both sides.
- Flags malformed encodings that the core turns into a trap.

---
 rtl/leb128_decoder_pkg.sv | 30 +++
 rtl/leb128_decoder_if.sv | 27 ++
 rtl/leb128_decoder_final_check.sv | 25 ++
 rtl/leb128_decoder.sv | 125 ++++++++++++
 tb/tb_leb128_decoder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/leb128_decoder_pkg.sv
// Shared types and constants for the LEB128 immediate decoder.
package leb_pkg;

  localparam int unsigned LEB_VALUE_W   = 64;
  localparam int unsigned LEB_LEN_W     = 4;
  localparam int unsigned LEB_SHIFT_W   = 7;
  localparam int unsigned LEB_PAYLOAD_W = 7;
  localparam int unsigned LEB_MAXB_32   = 5;
  localparam int unsigned LEB_MAXB_64   = 10;

  typedef enum logic [1:0] {
    LEB_U32 = 2'd0,
    LEB_S32 = 2'd1,
    LEB_U64 = 2'd2,
    LEB_S64 = 2'd3
  } leb_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } leb_state_t;

  // Longest legal encoding for a mode; a continuation bit on this byte is malformed.
  function automatic logic [LEB_LEN_W-1:0] leb_maxb(input leb_mode_t m);
    return ((m == LEB_U64) || (m == LEB_S64)) ? LEB_LEN_W'(LEB_MAXB_64)
                                              : LEB_LEN_W'(LEB_MAXB_32);
  endfunction

endpackage

// File: rtl/leb128_decoder_if.sv
// Request/byte-stream/result bundle between the byte extractor, decoder and execute stage.
interface leb128_decoder_if;
  import leb_pkg::*;

  logic                   start;
  logic [1:0]             mode;
  logic                   in_valid;
  logic [7:0]             in_byte;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [LEB_VALUE_W-1:0] value;
  logic [LEB_LEN_W-1:0]   length;
  logic                   error;
  logic                   busy;

  modport master (
    output start, mode, in_valid, in_byte, out_ready,
    input  in_ready, out_valid, value, length, error, busy
  );

  modport slave (
    input  start, mode, in_valid, in_byte, out_ready,
    output in_ready, out_valid, value, length, error, busy
  );

endinterface

// File: rtl/leb128_decoder_final_check.sv
// Validity of the terminating byte: unused high payload bits must be zero or a sign copy.
module leb_final_check
  import leb_pkg::*;
(
  input  leb_mode_t              mode,
  input  logic [LEB_LEN_W-1:0]   count,
  input  logic [6:0]             payload,
  output logic                   ok_c
);

  always_comb begin
    ok_c = 1'b1;
    // Only a byte in the last legal position can carry bits beyond the result width.
    if (count == leb_maxb(mode)) begin
      case (mode)
        LEB_U32: ok_c = (payload[6:4] == 3'd0);
        LEB_S32: ok_c = (payload[6:3] == {4{payload[3]}});
        LEB_U64: ok_c = (payload[6:1] == 6'd0);
        LEB_S64: ok_c = (payload == 7'h00) || (payload == 7'h7F);
        default: ok_c = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/leb128_decoder.sv
// One-byte-per-cycle LEB128 immediate decoder producing a 64-bit operand or a malformed flag.
module leb128_decoder
  import leb_pkg::*;
#(
  parameter bit USE_64B = 1'b1
) (
  input logic             clk,
  input logic             reset,
  leb128_decoder_if.slave bus
);

  leb_state_t             state_q;
  leb_mode_t              mode_q;
  logic [LEB_VALUE_W-1:0] acc_q;
  logic [LEB_SHIFT_W-1:0] shift_q;
  logic [LEB_LEN_W-1:0]   count_q;

  logic [LEB_VALUE_W-1:0] acc_next;
  logic [LEB_VALUE_W-1:0] ext_value;
  logic [LEB_VALUE_W-1:0] final_value;
  logic [LEB_SHIFT_W-1:0] shift_next;
  logic [LEB_LEN_W-1:0]   count_next;
  logic                   is_signed;
  logic                   at_maxb;
  logic                   last_ok;
  logic                   wide_blocked;

  leb_final_check u_final_check (
    .mode    (mode_q),
    .count   (count_next),
    .payload (bus.in_byte[6:0]),
    .ok_c    (last_ok)
  );

  // Accumulator update and result shaping for the byte currently presented.
  always_comb begin
    count_next  = count_q + LEB_LEN_W'(1);
    shift_next  = shift_q + LEB_SHIFT_W'(LEB_PAYLOAD_W);
    acc_next    = acc_q | (LEB_VALUE_W'(bus.in_byte[6:0]) << shift_q);
    is_signed   = (mode_q == LEB_S32) || (mode_q == LEB_S64);
    at_maxb     = (count_next == leb_maxb(mode_q));
    ext_value   = acc_next;
    if (is_signed && bus.in_byte[6] && (shift_next < LEB_SHIFT_W'(LEB_VALUE_W)))
      ext_value = acc_next | ({LEB_VALUE_W{1'b1}} << shift_next);
    case (mode_q)
      LEB_U32: final_value = {32'd0, ext_value[31:0]};
      LEB_S32: final_value = {{32{ext_value[31]}}, ext_value[31:0]};
      default: final_value = ext_value;
    endcase
    wide_blocked = !USE_64B && bus.mode[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mode_q        <= LEB_U32;
      acc_q         <= '0;
      shift_q       <= '0;
      count_q       <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.value     <= '0;
      bus.length    <= '0;
      bus.error     <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_q   <= leb_mode_t'(bus.mode);
            acc_q    <= '0;
            shift_q  <= '0;
            count_q  <= '0;
            bus.busy <= 1'b1;
            if (wide_blocked) begin
              state_q       <= DONE;
              bus.out_valid <= 1'b1;
              bus.value     <= '0;
              bus.length    <= '0;
              bus.error     <= 1'b1;
            end else begin
              state_q      <= ACCUM;
              bus.in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc_q   <= acc_next;
            shift_q <= shift_next;
            count_q <= count_next;
            // Terminate on a clear continuation bit, or on overlong input at MAXB.
            if (!bus.in_byte[7] || at_maxb) begin
              state_q       <= DONE;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
              bus.length    <= count_next;
              if (!bus.in_byte[7] && last_ok) begin
                bus.value <= final_value;
                bus.error <= 1'b0;
              end else begin
                bus.value <= '0;
                bus.error <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q       <= IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          bus.in_ready  <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed bench for leb128_decoder with hand-computed operand values.
module tb_leb128_decoder;
  import leb_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  leb128_decoder_if bus ();
  leb128_decoder_if bus32 ();

  leb128_decoder #(.USE_64B(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  leb128_decoder #(.USE_64B(1'b0)) dut_n64 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] stim[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] m);
    bus.start = 1'b1;
    bus.mode  = m;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed(input string tag, input logic [7:0] b);
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    check({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic retire(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "/busy_after"}, 64'(bus.busy), 64'd0);
    check({tag, "/ov_after"}, 64'(bus.out_valid), 64'd0);
  endtask

  // Feeds stim back-to-back; out_valid must rise exactly after the last byte.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [63:0] exp_v,
                        input logic [3:0] exp_len, input logic exp_err);
    start_op(m);
    for (int i = 0; i < stim.size(); i++) begin
      feed(tag, stim[i]);
      check({tag, "/out_valid"}, 64'(bus.out_valid), 64'(i == stim.size() - 1));
    end
    check({tag, "/value"}, bus.value, exp_v);
    check({tag, "/length"}, 64'(bus.length), 64'(exp_len));
    check({tag, "/error"}, 64'(bus.error), 64'(exp_err));
    check({tag, "/in_ready_done"}, 64'(bus.in_ready), 64'd0);
    retire(tag);
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.mode      = 2'd0;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.out_ready = 1'b0;
    bus32.start     = 1'b0;
    bus32.mode      = 2'd0;
    bus32.in_valid  = 1'b0;
    bus32.in_byte   = 8'h00;
    bus32.out_ready = 1'b0;
    tick();
    tick();
    check("rst/in_ready", 64'(bus.in_ready), 64'd0);
    check("rst/out_valid", 64'(bus.out_valid), 64'd0);
    check("rst/value", bus.value, 64'd0);
    check("rst/length", 64'(bus.length), 64'd0);
    check("rst/error", 64'(bus.error), 64'd0);
    check("rst/busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    tick();

    stim = {8'hE5, 8'h8E, 8'h26};
    run_op("u32_624485", 2'd0, 64'h0000_0000_0009_8765, 4'd3, 1'b0);
    stim = {8'hC0, 8'hBB, 8'h78};
    run_op("s32_neg", 2'd1, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 1'b0);
    stim = {8'h7F};
    run_op("s32_m1", 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 1'b0);
    stim = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    run_op("u32_max", 2'd0, 64'h0000_0000_FFFF_FFFF, 4'd5, 1'b0);
    stim = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};
    run_op("u32_ovf", 2'd0, 64'd0, 4'd5, 1'b1);
    stim = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    run_op("u32_long", 2'd0, 64'd0, 4'd5, 1'b1);
    stim = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    run_op("s32_5b_m1", 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 1'b0);
    stim = {8'h80, 8'h00};
    run_op("u64_pad0", 2'd2, 64'd0, 4'd2, 1'b0);
    stim = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    run_op("u64_max", 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0);
    stim = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    run_op("s64_m1", 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0);
    stim = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01};
    run_op("s64_bad", 2'd3, 64'd0, 4'd10, 1'b1);

    // 64-bit request on an instance without 64-bit support.
    check("n64/idle_ov", 64'(bus32.out_valid), 64'd0);
    bus32.start = 1'b1;
    bus32.mode  = 2'd3;
    tick();
    bus32.start = 1'b0;
    check("n64/out_valid", 64'(bus32.out_valid), 64'd1);
    check("n64/error", 64'(bus32.error), 64'd1);
    check("n64/length", 64'(bus32.length), 64'd0);
    check("n64/value", bus32.value, 64'd0);
    check("n64/in_ready", 64'(bus32.in_ready), 64'd0);
    bus32.out_ready = 1'b1;
    tick();
    bus32.out_ready = 1'b0;
    check("n64/busy_after", 64'(bus32.busy), 64'd0);

    // Result held under backpressure; start during DONE ignored.
    start_op(2'd0);
    feed("bp", 8'h05);
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1;
      bus.mode  = 2'd1;
      tick();
      check("bp/out_valid", 64'(bus.out_valid), 64'd1);
      check("bp/value", bus.value, 64'd5);
      check("bp/length", 64'(bus.length), 64'd1);
      check("bp/in_ready", 64'(bus.in_ready), 64'd0);
      check("bp/busy", 64'(bus.busy), 64'd1);
    end
    bus.start = 1'b0;
    retire("bp");

    // in_valid gap mid-operand.
    start_op(2'd0);
    feed("stall", 8'hE5);
    feed("stall", 8'h8E);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall/in_ready", 64'(bus.in_ready), 64'd1);
      check("stall/out_valid", 64'(bus.out_valid), 64'd0);
    end
    feed("stall", 8'h26);
    check("stall/out_valid_end", 64'(bus.out_valid), 64'd1);
    check("stall/value", bus.value, 64'h0000_0000_0009_8765);
    check("stall/length", 64'(bus.length), 64'd3);
    retire("stall");

    // Asynchronous reset mid-operand, then a fresh one-byte decode.
    start_op(2'd1);
    feed("abort", 8'hC0);
    feed("abort", 8'hBB);
    reset = 1'b1;
    #1;
    check("abort/busy", 64'(bus.busy), 64'd0);
    check("abort/out_valid", 64'(bus.out_valid), 64'd0);
    check("abort/in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("abort/no_result", 64'(bus.out_valid), 64'd0);
    bus.in_byte  = 8'h2A;
    bus.in_valid = 1'b1;
    start_op(2'd0);
    check("post/in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("post/out_valid", 64'(bus.out_valid), 64'd1);
    check("post/value", bus.value, 64'd42);
    check("post/length", 64'(bus.length), 64'd1);
    check("post/error", 64'(bus.error), 64'd0);
    retire("post");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
